// File: rtl/sha256_msg_sequencer.sv
// SHA-256 message sequencer: packs a byte stream into 512-bit blocks with FIPS 180-4 padding.
// Optional `abort` port enabled by defining SHA_SEQ_ABORT_EN.
module sha256_msg_sequencer #(
   parameter int unsigned LEN_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_first,
   output logic         blk_last,
   output logic         msg_done,
   output logic         busy
`ifdef SHA_SEQ_ABORT_EN
   ,
   input  logic         abort
`endif
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FILL  = 3'd1;
   localparam logic [2:0] PAD   = 3'd2;
   localparam logic [2:0] ISSUE = 3'd3;
   localparam logic [2:0] LEN   = 3'd4;

   localparam logic [LEN_W-1:0] CNT_ONE = 1;

   logic [2:0]       state;
   logic [5:0]       idx;
   logic [LEN_W-1:0] cnt;
   logic             first_pend;
   logic             len_pend;
   logic             len_pad80;
   logic             abort_i;
   logic             accept;
   logic             handshake;
   logic [63:0]      bit_len;

`ifdef SHA_SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign in_ready  = (state == IDLE) || (state == FILL);
   assign accept    = in_valid & in_ready;
   assign handshake = blk_valid & blk_ready;
   assign bit_len   = {{(61 - LEN_W){1'b0}}, cnt, 3'b000};

   // Byte i lives at bits [511-8i -: 8], i.e. base offset 8*(63-i) = {~i, 3'b000}.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         first_pend <= 1'b0;
         len_pend   <= 1'b0;
         len_pad80  <= 1'b0;
         blk_data   <= '0;
         blk_valid  <= 1'b0;
         blk_first  <= 1'b0;
         blk_last   <= 1'b0;
         msg_done   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         msg_done <= 1'b0;
         if (abort_i) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            first_pend <= 1'b0;
            len_pend   <= 1'b0;
            len_pad80  <= 1'b0;
            blk_data   <= '0;
            blk_valid  <= 1'b0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               IDLE, FILL: begin
                  if (accept) begin
                     blk_data[{~idx, 3'b000} +: 8] <= in_data;
                     idx <= idx + 6'd1;
                     cnt <= cnt + CNT_ONE;
                     if (state == IDLE) begin
                        busy       <= 1'b1;
                        first_pend <= 1'b1;
                     end
                     if (in_last) begin
                        state <= PAD;
                     end else if (idx == 6'd63) begin
                        state     <= ISSUE;
                        blk_valid <= 1'b1;
                        blk_first <= first_pend;
                        blk_last  <= 1'b0;
                     end else begin
                        state <= FILL;
                     end
                  end
               end
               PAD: begin
                  // idx holds p = k+1 modulo 64; zero means the data filled all 64 bytes.
                  if (idx == 6'd0) begin
                     len_pend  <= 1'b1;
                     len_pad80 <= 1'b1;
                     blk_last  <= 1'b0;
                  end else begin
                     blk_data[{~idx, 3'b000} +: 8] <= 8'h80;
                     if (idx <= 6'd55) begin
                        blk_data[63:0] <= bit_len;
                        blk_last       <= 1'b1;
                     end else begin
                        len_pend  <= 1'b1;
                        len_pad80 <= 1'b0;
                        blk_last  <= 1'b0;
                     end
                  end
                  state     <= ISSUE;
                  blk_valid <= 1'b1;
                  blk_first <= first_pend;
               end
               ISSUE: begin
                  if (handshake) begin
                     blk_valid  <= 1'b0;
                     blk_data   <= '0;
                     blk_first  <= 1'b0;
                     blk_last   <= 1'b0;
                     first_pend <= 1'b0;
                     idx        <= '0;
                     if (len_pend) begin
                        state <= LEN;
                     end else if (blk_last) begin
                        state    <= IDLE;
                        msg_done <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                     end else begin
                        state <= FILL;
                     end
                  end
               end
               LEN: begin
                  blk_data  <= {(len_pad80 ? 8'h80 : 8'h00), 440'd0, bit_len};
                  len_pend  <= 1'b0;
                  len_pad80 <= 1'b0;
                  blk_valid <= 1'b1;
                  blk_first <= first_pend;
                  blk_last  <= 1'b1;
                  state     <= ISSUE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Directed self-checking bench for sha256_msg_sequencer (abort scenario when SHA_SEQ_ABORT_EN is defined).
module tb_sha256_msg_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_ready;
   logic [511:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         blk_first;
   logic         blk_last;
   logic         msg_done;
   logic         busy;
`ifdef SHA_SEQ_ABORT_EN
   logic         abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]   msg [0:63];
   logic         cap_seen;
   logic [511:0] cap_data;
   logic         cap_first;
   logic         cap_last;
   logic         cap_done;
   logic         cap_busy;
   logic         cap_valid;

   localparam logic [511:0] ABC_BLK = {32'h61626380, 448'd0, 32'h00000018};

   always #5 clk = ~clk;

   sha256_msg_sequencer #(.LEN_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .msg_done  (msg_done),
      .busy      (busy)
`ifdef SHA_SEQ_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   // Feed msg[0..n-1]; returns at the negedge after the final byte's handshake.
   task automatic send_msg(input int n, input bit with_last);
      for (int i = 0; i < n; i++) begin
         int t;
         @(negedge clk);
         t = 0;
         while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready byte %0d: in_ready=%b expected 1", i, in_ready);
         end
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = with_last && (i == n - 1);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Waits (bounded) for a block, accepts it and records outputs one cycle later.
   task automatic take_block();
      int t;
      t = 0;
      while (blk_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      cap_seen  = (blk_valid === 1'b1);
      cap_data  = blk_data;
      cap_first = blk_first;
      cap_last  = blk_last;
      blk_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      blk_ready = 1'b0;
      cap_done  = msg_done;
      cap_busy  = busy;
      cap_valid = blk_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; blk_ready = 1'b0;
`ifdef SHA_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checks++; if (blk_data !== 512'd0) begin errors++; $display("FAIL reset_data got %h exp 0", blk_data); end
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", blk_valid); end
      checks++; if ({blk_first, blk_last} !== 2'b00) begin errors++; $display("FAIL reset_first_last got %b exp 00", {blk_first, blk_last}); end
      checks++; if ({msg_done, busy} !== 2'b00) begin errors++; $display("FAIL reset_done_busy got %b exp 00", {msg_done, busy}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_abc(input string tag);
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      send_msg(3, 1'b1);
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL %s_pad_cycle valid got %b exp 0", tag, blk_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b exp 1", tag, busy); end
      @(negedge clk);
      checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL %s_latency valid got %b exp 1", tag, blk_valid); end
      take_block();
      checks++; if (cap_seen !== 1'b1) begin errors++; $display("FAIL %s_timeout seen %b exp 1", tag, cap_seen); end
      checks++; if (cap_data !== ABC_BLK) begin errors++; $display("FAIL %s_data got %h exp %h", tag, cap_data, ABC_BLK); end
      checks++; if ({cap_first, cap_last} !== 2'b11) begin errors++; $display("FAIL %s_first_last got %b exp 11", tag, {cap_first, cap_last}); end
      checks++; if ({cap_done, cap_busy, cap_valid} !== 3'b100) begin errors++; $display("FAIL %s_done got done/busy/valid %b exp 100", tag, {cap_done, cap_busy, cap_valid}); end
      @(negedge clk);
      checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b exp 0", tag, msg_done); end
      checks++; if (blk_data !== 512'd0) begin errors++; $display("FAIL %s_cleared got %h exp 0", tag, blk_data); end
   endtask

   task automatic test_pad55();
      logic [511:0] exp;
      for (int i = 0; i < 55; i++) msg[i] = 8'h00;
      exp = {440'd0, 8'h80, 32'd0, 32'h000001B8};
      send_msg(55, 1'b1);
      take_block();
      checks++; if (cap_seen !== 1'b1) begin errors++; $display("FAIL pad55_timeout seen %b exp 1", cap_seen); end
      checks++; if (cap_data !== exp) begin errors++; $display("FAIL pad55_data got %h exp %h", cap_data, exp); end
      checks++; if ({cap_first, cap_last, cap_done} !== 3'b111) begin errors++; $display("FAIL pad55_flags got first/last/done %b exp 111", {cap_first, cap_last, cap_done}); end
   endtask

   task automatic test_pad56();
      logic [511:0] exp0, exp1;
      for (int i = 0; i < 56; i++) msg[i] = 8'hAA;
      exp0 = {{56{8'hAA}}, 8'h80, 56'd0};
      exp1 = {480'd0, 32'h000001C0};
      send_msg(56, 1'b1);
      take_block();
      checks++; if (cap_data !== exp0) begin errors++; $display("FAIL pad56_blk0 got %h exp %h", cap_data, exp0); end
      checks++; if ({cap_first, cap_last} !== 2'b10) begin errors++; $display("FAIL pad56_blk0_flags got %b exp 10", {cap_first, cap_last}); end
      checks++; if ({cap_done, cap_busy} !== 2'b01) begin errors++; $display("FAIL pad56_mid got done/busy %b exp 01", {cap_done, cap_busy}); end
      take_block();
      checks++; if (cap_seen !== 1'b1) begin errors++; $display("FAIL pad56_blk1_timeout seen %b exp 1", cap_seen); end
      checks++; if (cap_data !== exp1) begin errors++; $display("FAIL pad56_blk1 got %h exp %h", cap_data, exp1); end
      checks++; if ({cap_first, cap_last, cap_done} !== 3'b011) begin errors++; $display("FAIL pad56_blk1_flags got first/last/done %b exp 011", {cap_first, cap_last, cap_done}); end
   endtask

   task automatic test_pad64();
      logic [511:0] exp0, exp1;
      for (int i = 0; i < 64; i++) msg[i] = 8'h11;
      exp0 = {64{8'h11}};
      exp1 = {32'h80000000, 448'd0, 32'h00000200};
      send_msg(64, 1'b1);
      take_block();
      checks++; if (cap_data !== exp0) begin errors++; $display("FAIL pad64_blk0 got %h exp %h", cap_data, exp0); end
      checks++; if ({cap_first, cap_last, cap_done} !== 3'b100) begin errors++; $display("FAIL pad64_blk0_flags got first/last/done %b exp 100", {cap_first, cap_last, cap_done}); end
      take_block();
      checks++; if (cap_data !== exp1) begin errors++; $display("FAIL pad64_blk1 got %h exp %h", cap_data, exp1); end
      checks++; if ({cap_first, cap_last, cap_done, cap_busy} !== 4'b0110) begin errors++; $display("FAIL pad64_blk1_flags got first/last/done/busy %b exp 0110", {cap_first, cap_last, cap_done, cap_busy}); end
   endtask

   task automatic test_stall_reset();
      int t;
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      send_msg(3, 1'b1);
      t = 0;
      while (blk_valid !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = 8'hFF;
         @(negedge clk);
         checks++;
         if (blk_valid !== 1'b1 || blk_data !== ABC_BLK || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cycle %0d valid=%b in_ready=%b data=%h exp valid=1 in_ready=0 data=%h", c, blk_valid, in_ready, blk_data, ABC_BLK);
         end
      end
      in_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({blk_valid, busy} !== 2'b00) begin errors++; $display("FAIL stall_reset valid/busy got %b exp 00", {blk_valid, busy}); end
      checks++; if (blk_data !== 512'd0) begin errors++; $display("FAIL stall_reset_data got %h exp 0", blk_data); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_abc("after_reset");
   endtask

`ifdef SHA_SEQ_ABORT_EN
   task automatic test_abort();
      bit seen;
      for (int i = 0; i < 30; i++) msg[i] = 8'h5A;
      send_msg(30, 1'b0);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      checks++; if ({busy, blk_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL abort_state busy/valid/in_ready got %b exp 001", {busy, blk_valid, in_ready}); end
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (blk_valid !== 1'b0 || msg_done !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet activity %b exp 0", seen); end
      test_abc("after_abort");
   endtask
`endif

   initial begin
      test_reset();
      test_abc("abc");
      test_pad55();
      test_pad56();
      test_pad64();
      test_abc("back_to_back");
      test_stall_reset();
`ifdef SHA_SEQ_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
